// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter (CPU MEM stage / debug master) in front of data_ram port A.
// Every access runs IDLE -> ISSUE -> RESP and ends with a single-cycle done pulse to its owner.
module dm_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_wen,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic [3:0]        dbg_wen,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [31:0]       rdata,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);

  localparam int                CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]     LIM = CW'(STARVE_LIMIT);
  localparam logic              OWN_CPU = 1'b0;
  localparam logic              OWN_DBG = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner, last;
  logic [CW-1:0] starve_cnt;
  logic [3:0]    wen_q;
  logic [31:0]   addr_q, wdata_q;
  logic          oor_q;
  logic          gnt_dbg;
  logic [31:0]   sel_addr;

  // Grant decision, only meaningful in IDLE with at least one request.
  always_comb begin
    gnt_dbg = dbg_req;
    if (cpu_req && dbg_req) begin
      if (ARB_MODE == 0) gnt_dbg = ~last;
      else               gnt_dbg = (starve_cnt == LIM);
    end
  end

  assign sel_addr = gnt_dbg ? dbg_addr : cpu_addr;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req || dbg_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture and arbitration history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner      <= OWN_CPU;
      last       <= OWN_DBG;
      starve_cnt <= '0;
      wen_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
    end else if (state == IDLE) begin
      if (!dbg_req)
        starve_cnt <= '0;
      else if (cpu_req && !gnt_dbg && starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
      else if (gnt_dbg)
        starve_cnt <= '0;
      if (cpu_req || dbg_req) begin
        owner   <= gnt_dbg;
        last    <= gnt_dbg;
        wen_q   <= gnt_dbg ? dbg_wen   : cpu_wen;
        addr_q  <= sel_addr;
        wdata_q <= gnt_dbg ? dbg_wdata : cpu_wdata;
        oor_q   <= (sel_addr[31:ADDR_W+2] != '0);
      end
    end
  end

  // Outputs are gated by resetn so an access caught mid-flight by reset never writes the RAM.
  always_comb begin
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    dbg_done  = 1'b0;
    dbg_err   = 1'b0;
    rdata     = '0;
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = resetn && (state != IDLE);
    if (resetn) begin
      if (state == ISSUE) begin
        ram_addr  = addr_q[ADDR_W+1:2];
        ram_wdata = wdata_q;
        ram_wen   = oor_q ? 4'h0 : wen_q;
      end
      if (state == RESP) begin
        if (owner == OWN_DBG) begin
          dbg_done = 1'b1;
          dbg_err  = oor_q;
        end else begin
          cpu_done = 1'b1;
          cpu_err  = oor_q;
        end
        if (wen_q == 4'h0 && !oor_q) rdata = ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter share stimulus, each with its own RAM model.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, dbg_req;
  logic [3:0]  cpu_wen, dbg_wen;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        cpu_done [2], cpu_err [2], dbg_done [2], dbg_err [2], busy [2];
  logic [31:0] rdata [2], ram_wdata [2], ram_rdata [2];
  logic [3:0]  ram_wen [2];
  logic [7:0]  ram_addr [2];
  logic [31:0] mem [2][256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(8), .ARB_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done[0]), .cpu_err(cpu_err[0]),
    .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done[0]), .dbg_err(dbg_err[0]),
    .rdata(rdata[0]), .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0]), .busy(busy[0]));

  dm_port_arbiter #(.ADDR_W(8), .ARB_MODE(1), .STARVE_LIMIT(4)) u_fx (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done[1]), .cpu_err(cpu_err[1]),
    .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done[1]), .dbg_err(dbg_err[1]),
    .rdata(rdata[1]), .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1]), .busy(busy[1]));

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = 32'h0;
  end

  // Synchronous RAM, one-cycle read latency, byte write enables.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[k][b]) mem[k][ram_addr[k]][b*8 +: 8] <= ram_wdata[k][b*8 +: 8];
      ram_rdata[k] <= mem[k][ram_addr[k]];
    end
  end

  typedef struct {
    logic        dbg;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  exp_ra;
    logic [3:0]  exp_wen;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic access(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_wen = v.wen; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk({s, "_issue_busy"}, k, busy[k], 1);
      chk({s, "_ram_addr"}, k, ram_addr[k], v.exp_ra);
      chk({s, "_ram_wen"}, k, ram_wen[k], v.exp_wen);
      chk({s, "_ram_wdata"}, k, ram_wdata[k], v.wdata);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk({s, "_own_done"}, k, v.dbg ? dbg_done[k] : cpu_done[k], 1);
      chk({s, "_other_done"}, k, v.dbg ? cpu_done[k] : dbg_done[k], 0);
      chk({s, "_err"}, k, v.dbg ? dbg_err[k] : cpu_err[k], v.exp_err);
      chk({s, "_rdata"}, k, rdata[k], v.exp_rd);
      chk({s, "_resp_ram_wen"}, k, ram_wen[k], 0);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  logic gseq [2][8];
  int   gn [2];
  logic exp_rr [6];
  logic exp_fx [6];
  int   stray;

  initial begin
    vec[0]  = '{1'b0, 4'hF, 32'h10,  32'hDEADBEEF, 8'h04, 4'hF, 1'b0, 32'h0};
    vec[1]  = '{1'b0, 4'h0, 32'h10,  32'h0,        8'h04, 4'h0, 1'b0, 32'hDEADBEEF};
    vec[2]  = '{1'b1, 4'h3, 32'h13,  32'h00001234, 8'h04, 4'h3, 1'b0, 32'h0};
    vec[3]  = '{1'b1, 4'h0, 32'h10,  32'h0,        8'h04, 4'h0, 1'b0, 32'hDEAD1234};
    vec[4]  = '{1'b1, 4'h0, 32'h400, 32'h0,        8'h00, 4'h0, 1'b1, 32'h0};
    vec[5]  = '{1'b0, 4'hF, 32'h3FC, 32'hA5A55A5A, 8'hFF, 4'hF, 1'b0, 32'h0};
    vec[6]  = '{1'b0, 4'hF, 32'h800, 32'hFFFFFFFF, 8'h00, 4'h0, 1'b1, 32'h0};
    vec[7]  = '{1'b0, 4'h0, 32'h0,   32'h0,        8'h00, 4'h0, 1'b0, 32'h0};
    vec[8]  = '{1'b1, 4'h0, 32'h3FC, 32'h0,        8'hFF, 4'h0, 1'b0, 32'hA5A55A5A};
    vec[9]  = '{1'b0, 4'hC, 32'h3FD, 32'h11112222, 8'hFF, 4'hC, 1'b0, 32'h0};
    vec[10] = '{1'b0, 4'h0, 32'h3FC, 32'h0,        8'hFF, 4'h0, 1'b0, 32'h11115A5A};
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_fx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    resetn = 1'b0;
    cpu_req = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_wen = 4'h0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy[k], 0);
      chk("rst_done", k, {cpu_done[k], cpu_err[k], dbg_done[k], dbg_err[k]}, 0);
      chk("rst_rdata", k, rdata[k], 0);
      chk("rst_ram", k, {ram_wen[k], ram_addr[k]} | ram_wdata[k], 0);
    end
    resetn = 1'b1;

    // Both requests held: RR alternates CPU first; fixed gives 4 CPU then 1 DBG.
    @(negedge clk);
    cpu_req = 1'b1; dbg_req = 1'b1;
    gn[0] = 0; gn[1] = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (cpu_done[k] && gn[k] < 8) begin gseq[k][gn[k]] = 1'b0; gn[k]++; end
        if (dbg_done[k] && gn[k] < 8) begin gseq[k][gn[k]] = 1'b1; gn[k]++; end
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("arb_grant_count", k, gn[k], 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), 0, gseq[0][i], exp_rr[i]);
      chk($sformatf("fx_grant%0d", i), 1, gseq[1][i], exp_fx[i]);
    end

    for (int i = 0; i < 11; i++) access(vec[i], i);

    // Reset during the ISSUE cycle of a write must suppress the write and the done pulse.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wen = 4'hF; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("mid_issue_wen", k, ram_wen[k], 4'hF);
    resetn = 1'b0;
    cpu_req = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("mid_rst_wen", k, ram_wen[k], 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_busy", k, busy[k], 0);
      chk("mid_rst_done", k, {cpu_done[k], dbg_done[k]}, 0);
      chk("mid_rst_rdata", k, rdata[k], 0);
    end
    resetn = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (cpu_done[k] || dbg_done[k] || busy[k]) stray++;
    end
    chk("post_rst_quiet", 0, stray, 0);
    for (int k = 0; k < 2; k++) chk("post_rst_mem", k, mem[k][8], 0);
    access('{1'b0, 4'h0, 32'h20, 32'h0, 8'h08, 4'h0, 1'b0, 32'h0}, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
